// File: rtl/camera_ctrl_pkg.sv
// Shared types and constants for the camera frame sequencer.
// Frame counter option is enabled in the top by CAMERA_CTRL_FRAME_CNT_EN.
package camera_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXPOSE  = 2'd1,
    ST_READOUT = 2'd2
  } state_t;

  localparam int RD_STEPS = 8;

  localparam logic [2:0] RD_NRE1_ON  = 3'd0;
  localparam logic [2:0] RD_NRE1_ADC = 3'd1;
  localparam logic [2:0] RD_NRE1_OFF = 3'd2;
  localparam logic [2:0] RD_GAP1     = 3'd3;
  localparam logic [2:0] RD_NRE2_ON  = 3'd4;
  localparam logic [2:0] RD_NRE2_ADC = 3'd5;
  localparam logic [2:0] RD_NRE2_OFF = 3'd6;
  localparam logic [2:0] RD_GAP2     = 3'd7;
  localparam logic [2:0] RD_LAST     = 3'(RD_STEPS - 1);

  localparam int EXP_MIN_DEF     = 2;
  localparam int EXP_MAX_DEF     = 30;
  localparam int EXP_DEFAULT_DEF = 10;

  typedef struct packed {
    logic nre_1;
    logic nre_2;
    logic adc;
  } rd_out_t;

  // Row-select/ADC pattern for one readout step; rows never overlap.
  function automatic rd_out_t rd_decode(input logic active, input logic [2:0] step);
    rd_out_t o;
    o = '{nre_1: 1'b1, nre_2: 1'b1, adc: 1'b0};
    if (active) begin
      case (step)
        RD_NRE1_ON:  o = '{nre_1: 1'b0, nre_2: 1'b1, adc: 1'b0};
        RD_NRE1_ADC: o = '{nre_1: 1'b0, nre_2: 1'b1, adc: 1'b1};
        RD_NRE1_OFF: o = '{nre_1: 1'b0, nre_2: 1'b1, adc: 1'b0};
        RD_GAP1:     o = '{nre_1: 1'b1, nre_2: 1'b1, adc: 1'b0};
        RD_NRE2_ON:  o = '{nre_1: 1'b1, nre_2: 1'b0, adc: 1'b0};
        RD_NRE2_ADC: o = '{nre_1: 1'b1, nre_2: 1'b0, adc: 1'b1};
        RD_NRE2_OFF: o = '{nre_1: 1'b1, nre_2: 1'b0, adc: 1'b0};
        RD_GAP2:     o = '{nre_1: 1'b1, nre_2: 1'b1, adc: 1'b0};
        default:     o = '{nre_1: 1'b1, nre_2: 1'b1, adc: 1'b0};
      endcase
    end else begin
      o = '{nre_1: 1'b1, nre_2: 1'b1, adc: 1'b0};
    end
    return o;
  endfunction

endpackage

// File: rtl/camera_ctrl_fsm_exp_down_counter.sv
// Exposure down-counter: loads the exposure length, counts down to 1.
// done flags the final exposure cycle.
module exp_down_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] count,
  output logic         done
);

  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;

  // Load has priority over decrement; never wraps below zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= ZERO;
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != ZERO)) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign done  = (count_r == ONE);

endmodule

// File: rtl/camera_ctrl_fsm.sv
// Camera frame sequencer: erase, timed exposure, two-row ADC readout.
// Optional frame_cnt output enabled by macro CAMERA_CTRL_FRAME_CNT_EN.
module camera_ctrl_fsm
  import camera_ctrl_pkg::*;
#(
  parameter int EXP_W       = 5,
  parameter int EXP_MIN     = EXP_MIN_DEF,
  parameter int EXP_MAX     = EXP_MAX_DEF,
  parameter int EXP_DEFAULT = EXP_DEFAULT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             exp_increase,
  input  logic             exp_decrease,
  output logic             erase,
  output logic             expose,
  output logic             nre_1,
  output logic             nre_2,
  output logic             adc,
  output logic [EXP_W-1:0] exp_time,
`ifdef CAMERA_CTRL_FRAME_CNT_EN
  output logic [7:0]       frame_cnt,
`endif
  output logic             busy
);

  localparam logic [EXP_W-1:0] EXP_MIN_V     = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] EXP_MAX_V     = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] EXP_DEFAULT_V = EXP_W'(EXP_DEFAULT);
  localparam logic [EXP_W-1:0] EXP_ONE       = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] EXP_ZERO      = {EXP_W{1'b0}};

  state_t           state_r, state_s;
  logic [2:0]       rd_step_r, rd_step_s;
  logic [EXP_W-1:0] exp_time_r, exp_time_s;
  logic             inc_d_r, dec_d_r;
  logic             inc_rise_s, dec_rise_s;
  logic             cnt_load_s, cnt_en_s, cnt_done_s;
  logic [EXP_W-1:0] cnt_val_s;
  rd_out_t          rd_o_s;

  exp_down_counter #(.W(EXP_W)) u_exp_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load_s),
    .enable     (cnt_en_s),
    .load_value (exp_time_r),
    .count      (cnt_val_s),
    .done       (cnt_done_s)
  );

  assign inc_rise_s = exp_increase & ~inc_d_r;
  assign dec_rise_s = exp_decrease & ~dec_d_r;

  // Next-state, readout step and exposure setting.
  always_comb begin
    state_s    = state_r;
    rd_step_s  = rd_step_r;
    exp_time_s = exp_time_r;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        rd_step_s = 3'd0;
        if (inc_rise_s && !dec_rise_s) begin
          if (exp_time_r < EXP_MAX_V) exp_time_s = exp_time_r + EXP_ONE;
          else                        exp_time_s = EXP_MAX_V;
        end else if (dec_rise_s && !inc_rise_s) begin
          if (exp_time_r > EXP_MIN_V) exp_time_s = exp_time_r - EXP_ONE;
          else                        exp_time_s = EXP_MIN_V;
        end else begin
          exp_time_s = exp_time_r;
        end
        // Counter takes the pre-update setting when init coincides with a step.
        if (init) begin
          state_s    = ST_EXPOSE;
          cnt_load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXPOSE: begin
        if (cnt_val_s == EXP_ZERO) begin
          state_s = ST_IDLE;
        end else if (cnt_done_s) begin
          state_s   = ST_READOUT;
          rd_step_s = 3'd0;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      ST_READOUT: begin
        if (rd_step_r == RD_LAST) begin
          state_s   = ST_IDLE;
          rd_step_s = 3'd0;
        end else begin
          rd_step_s = rd_step_r + 3'd1;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        rd_step_s = 3'd0;
      end
    endcase
  end

  assign rd_o_s = rd_decode(state_s == ST_READOUT, rd_step_s);

  // State, exposure setting and input edge history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      rd_step_r  <= 3'd0;
      exp_time_r <= EXP_DEFAULT_V;
      inc_d_r    <= 1'b0;
      dec_d_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      rd_step_r  <= rd_step_s;
      exp_time_r <= exp_time_s;
      inc_d_r    <= exp_increase;
      dec_d_r    <= exp_decrease;
    end
  end

  // Array control lines registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      erase  <= 1'b1;
      expose <= 1'b0;
      nre_1  <= 1'b1;
      nre_2  <= 1'b1;
      adc    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      erase  <= (state_s == ST_IDLE);
      expose <= (state_s == ST_EXPOSE);
      nre_1  <= rd_o_s.nre_1;
      nre_2  <= rd_o_s.nre_2;
      adc    <= rd_o_s.adc;
      busy   <= (state_s != ST_IDLE);
    end
  end

  assign exp_time = exp_time_r;

`ifdef CAMERA_CTRL_FRAME_CNT_EN
  logic [7:0] frame_cnt_r;

  // Completed-frame counter, wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_r <= 8'd0;
    end else if ((state_r == ST_READOUT) && (rd_step_r == RD_LAST)) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_camera_ctrl_fsm.sv
// Directed self-checking bench for camera_ctrl_fsm.
// Frame-counter scenario runs only when CAMERA_CTRL_FRAME_CNT_EN is defined.
module tb_camera_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic       exp_increase = 1'b0;
  logic       exp_decrease = 1'b0;
  logic       erase, expose, nre_1, nre_2, adc, busy;
  logic [4:0] exp_time;
`ifdef CAMERA_CTRL_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // {erase, expose, nre_1, nre_2, adc, busy}
  localparam logic [5:0] V_IDLE = 6'b101100;
  localparam logic [5:0] V_EXP  = 6'b011101;
  logic [5:0] rd_exp [8] = '{6'b000101, 6'b000111, 6'b000101, 6'b001101,
                             6'b001001, 6'b001011, 6'b001001, 6'b001101};

  always #5 clk = ~clk;

  camera_ctrl_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .exp_increase (exp_increase),
    .exp_decrease (exp_decrease),
    .erase        (erase),
    .expose       (expose),
    .nre_1        (nre_1),
    .nre_2        (nre_2),
    .adc          (adc),
    .exp_time     (exp_time),
`ifdef CAMERA_CTRL_FRAME_CNT_EN
    .frame_cnt    (frame_cnt),
`endif
    .busy         (busy)
  );

  function automatic logic [5:0] outs();
    return {erase, expose, nre_1, nre_2, adc, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc();
    exp_increase = 1'b1; tick();
    exp_increase = 1'b0; tick();
  endtask

  task automatic pulse_dec();
    exp_decrease = 1'b1; tick();
    exp_decrease = 1'b0; tick();
  endtask

  // One frame from IDLE: t exposure cycles, 8 readout steps, back to IDLE.
  task automatic run_frame(input int t, input logic with_inc, input logic [4:0] exp_after,
                           input string name);
    init = 1'b1; exp_increase = with_inc;
    tick();
    init = 1'b0; exp_increase = 1'b0;
    for (int i = 0; i < t; i++) begin
      checks++;
      if (outs() !== V_EXP) begin
        failures++;
        $display("FAIL %s expose cycle %0d: got %b want %b", name, i, outs(), V_EXP);
      end
      tick();
    end
    for (int s = 0; s < 8; s++) begin
      checks++;
      if (outs() !== rd_exp[s]) begin
        failures++;
        $display("FAIL %s readout step %0d: got %b want %b", name, s, outs(), rd_exp[s]);
      end
      tick();
    end
    checks++;
    if (outs() !== V_IDLE) begin
      failures++;
      $display("FAIL %s idle after frame: got %b want %b", name, outs(), V_IDLE);
    end
    checks++;
    if (exp_time !== exp_after) begin
      failures++;
      $display("FAIL %s exp_time: got %0d want %0d", name, exp_time, exp_after);
    end
  endtask

  task automatic test_reset();
    #12 reset = 1'b0;
    tick();
    checks++;
    if (outs() !== V_IDLE) begin
      failures++;
      $display("FAIL reset_outputs: got %b want %b", outs(), V_IDLE);
    end
    checks++;
    if (exp_time !== 5'd10) begin
      failures++;
      $display("FAIL reset_exp_time: got %0d want 10", exp_time);
    end
  endtask

  task automatic test_default_frame();
    run_frame(10, 1'b0, 5'd10, "default_frame");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 25; i++) pulse_inc();
    checks++;
    if (exp_time !== 5'd30) begin
      failures++;
      $display("FAIL sat_max: got %0d want 30", exp_time);
    end
    for (int i = 0; i < 40; i++) pulse_dec();
    checks++;
    if (exp_time !== 5'd2) begin
      failures++;
      $display("FAIL sat_min: got %0d want 2", exp_time);
    end
    run_frame(2, 1'b0, 5'd2, "min_frame");
  endtask

  task automatic test_edges();
    pulse_inc();
    exp_increase = 1'b1; exp_decrease = 1'b1; tick();
    exp_increase = 1'b0; exp_decrease = 1'b0; tick();
    checks++;
    if (exp_time !== 5'd3) begin
      failures++;
      $display("FAIL both_edges: got %0d want 3", exp_time);
    end
    exp_increase = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    exp_increase = 1'b0; tick();
    checks++;
    if (exp_time !== 5'd4) begin
      failures++;
      $display("FAIL held_inc: got %0d want 4", exp_time);
    end
  endtask

  task automatic test_back_to_back();
    init = 1'b1;
    tick();
    for (int c = 0; c < 39; c++) begin
      int ph;
      logic [5:0] want;
      ph = c % 13;
      if (ph < 4) want = V_EXP;
      else if (ph < 12) want = rd_exp[ph - 4];
      else want = V_IDLE;
      checks++;
      if (outs() !== want) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got %b want %b", c, outs(), want);
      end
      if (ph == 1) exp_increase = 1'b1;
      else exp_increase = 1'b0;
      if (c == 38) init = 1'b0;
      tick();
    end
    checks++;
    if ((outs() !== V_IDLE) || (exp_time !== 5'd4)) begin
      failures++;
      $display("FAIL back_to_back end: got %b exp %0d want %b exp 4", outs(), exp_time, V_IDLE);
    end
  endtask

  task automatic test_init_with_inc();
    tick();
    run_frame(4, 1'b1, 5'd5, "init_with_inc");
  endtask

  task automatic test_reset_mid_expose();
    init = 1'b1; tick();
    init = 1'b0; tick(); tick();
    checks++;
    if (outs() !== V_EXP) begin
      failures++;
      $display("FAIL mid_reset precondition: got %b want %b", outs(), V_EXP);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ((outs() !== V_IDLE) || (exp_time !== 5'd10)) begin
      failures++;
      $display("FAIL mid_reset async: got %b exp %0d want %b exp 10", outs(), exp_time, V_IDLE);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (outs() !== V_IDLE) begin
      failures++;
      $display("FAIL mid_reset release: got %b want %b", outs(), V_IDLE);
    end
  endtask

`ifdef CAMERA_CTRL_FRAME_CNT_EN
  task automatic test_frame_cnt();
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL frame_cnt reset: got %0d want 0", frame_cnt);
    end
    for (int f = 0; f < 257; f++) run_frame(10, 1'b0, 5'd10, "fc_frame");
    checks++;
    if (frame_cnt !== 8'd1) begin
      failures++;
      $display("FAIL frame_cnt wrap: got %0d want 1", frame_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_frame();
    test_saturation();
    test_edges();
    test_back_to_back();
    test_init_with_inc();
    test_reset_mid_expose();
`ifdef CAMERA_CTRL_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
